counter_skip_set: RTL and testbench
===================================

// Module: counter_skip_set
// PURPOSE
//  Parametrised up-counter that never presents a value held in a runtime-programmable skip table.
//  Generalises the fixed "count except 3" counter: width, wrap point and number of skip entries are parameters.
//  Adds enable, load and terminal-count outputs.
//  Used as a sequence/slot generator where reserved codes must never appear on cnt.
// PARAMETERS
//  N        5        counter width in bits
//  MAX_VAL  2**N-1   last value before wrap; MAX_VAL <= 2**N-1
//  K        4        number of skip-table entries, K >= 1
//  RST_SKIP 3        value loaded into skip entry 0 at reset; entry 0 is valid at reset
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          synchronous, active-high reset
//  en        in   1          advance one step this cycle
//  load      in   1          load load_val this cycle; has priority over en
//  load_val  in   N          load value
//  cfg_we    in   1          write skip entry cfg_idx
//  cfg_idx   in   $clog2(K)  skip entry index; clog2 floored at 1 bit
//  cfg_val   in   N          skip value to write
//  cfg_vld   in   1          valid bit to write; 0 disables the entry
//  cnt       out  N          current count, registered
//  tc        out  1          one-cycle pulse, registered; high in the cycle after a wrapping step
// BEHAVIOUR
//  Reset:
//   - cnt=0 and tc=0.
//   - Skip entry 0 = {RST_SKIP, valid}; entries 1..K-1 are invalid.
//   - cnt resets to 0 even if 0 is skipped; the first step moves off it.
//  Step when en=1 and load=0:
//   - cnt <= first candidate in cnt+1, cnt+2, ... that matches no valid skip entry.
//   - The successor of MAX_VAL is 0.
//   - The search covers at most K+1 candidates.
//   - If all K+1 candidates are skipped, cnt holds and tc stays 0.
//  tc:
//   - tc=1 in the cycle after any step whose search passed MAX_VAL->0, including 0 itself skipped.
//   - tc=0 otherwise, and on every load.
//  Load when load=1:
//   - cnt <= load_val if load_val is not skipped; otherwise the first non-skipped value above it, same search.
//   - load_val > MAX_VAL is treated as 0.
//   - load overrides en in the same cycle.
//  Config: a table write takes effect in the next cycle. A step or load in the same cycle uses the old table.
//  cnt becoming skipped: if a write makes the current cnt a skipped value, cnt is NOT changed. The next step or load moves it off.
//  Arithmetic: all compares are N bits. The wrap is an explicit compare against MAX_VAL, never natural overflow.
//  Reset mid-operation: rst overrides load, en and cfg_we. The outputs above appear in the next cycle.
// CONFIGURATION
//  COUNTER_SKIP_DOWN_EN defined:
//   - Adds input port dir (1 bit). dir=1 counts down; the successor of 0 is MAX_VAL.
//   - The skip search runs downward with the same K+1 bound.
//   - tc pulses after a step that passes 0->MAX_VAL.
//   - The load search direction follows dir.
//  Not defined: no dir port; up-count only, exactly as above.
// STRUCTURE
//  Package counter_skip_pkg:
//   - default constants (N_DEF=5, K_DEF=4, RST_SKIP_DEF=3).
//   - typedef enum {DIR_UP, DIR_DOWN} dir_e.
//  Sub-module counter_skip_search:
//   - Combinational; inputs start value, direction, skip table; outputs next value, wrapped flag, found flag.
//   - Instanced twice: step path (start=cnt) and load path (start=load_val-1 up / +1 down, so load_val itself is tested first).
// TESTING
//  T1 reset, en=1 continuous (N=5, MAX_VAL=31) -> cnt 0,1,2,4,...,31,0; tc=1 only in the cycle after 31->0.
//  T2 write entries 1=4, 2=5; count from 2 -> next cnt=6; clear entry 1 -> 2 steps to 4 after next wrap.
//  T3 with 3,4,5 skipped: load=1, load_val=3 and en=1 together -> cnt=6, tc=0.
//  T4 skip 31 and 0: step from 30 -> cnt=1 and tc pulses once.
//  T5 rst=1 at cnt=17 with cfg_we=1 -> next cycle cnt=0, tc=0, table = {3 valid, rest invalid}.
//  T6 (COUNTER_SKIP_DOWN_EN) dir=1 from 4 -> 2; from 0 -> 31 with tc pulse.

Source files
------------

// File: rtl/counter_skip_pkg.sv
// Shared constants and types for the skip-table counter.
package counter_skip_pkg;

  localparam int N_DEF        = 5;
  localparam int K_DEF        = 4;
  localparam int RST_SKIP_DEF = 3;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

endpackage

// File: rtl/counter_skip_search.sv
// Combinational skip search: walks up to K+1 successors of start (wrapping
// at MAX_VAL / 0) and returns the first one absent from the valid skip entries.
module counter_skip_search
  import counter_skip_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAX_VAL = (1 << N) - 1,
  parameter int K       = K_DEF
)(
  input  logic [N-1:0]        start,
  input  dir_e                dir,
  input  logic [K-1:0][N-1:0] skip_val,
  input  logic [K-1:0]        skip_vld,
  output logic [N-1:0]        nxt,
  output logic                wrapped,
  output logic                found
);

  localparam logic [N-1:0] MAX_C = MAX_VAL[N-1:0];
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cand;
  logic         wrap_acc;
  logic         done;
  logic         hit;

  // Unrolled candidate walk; wrap_acc remembers whether the boundary was crossed
  always_comb begin
    cand     = start;
    wrap_acc = 1'b0;
    done     = 1'b0;
    hit      = 1'b0;
    nxt      = start;
    wrapped  = 1'b0;
    found    = 1'b0;
    for (int s = 0; s < K + 1; s++) begin
      if (!done) begin
        if (dir == DIR_DOWN) begin
          if (cand == '0) begin
            cand     = MAX_C;
            wrap_acc = 1'b1;
          end else begin
            cand = cand - ONE;
          end
        end else begin
          if (cand == MAX_C) begin
            cand     = '0;
            wrap_acc = 1'b1;
          end else begin
            cand = cand + ONE;
          end
        end
        hit = 1'b0;
        for (int e = 0; e < K; e++) begin
          if (skip_vld[e] && (skip_val[e] == cand)) hit = 1'b1;
        end
        if (!hit) begin
          done    = 1'b1;
          nxt     = cand;
          wrapped = wrap_acc;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_skip_set.sv
// Up-counter that never presents a value held in a programmable skip table.
// Optional feature macro: COUNTER_SKIP_DOWN_EN adds a dir port for down-counting.
module counter_skip_set
  import counter_skip_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_VAL  = (1 << N) - 1,
  parameter int K        = K_DEF,
  parameter int RST_SKIP = RST_SKIP_DEF,
  localparam int IW      = (K > 1) ? $clog2(K) : 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [N-1:0]  cfg_val,
  input  logic          cfg_vld,
`ifdef COUNTER_SKIP_DOWN_EN
  input  logic          dir,
`endif
  output logic [N-1:0]  cnt,
  output logic          tc
);

  localparam logic [N-1:0] MAX_C = MAX_VAL[N-1:0];
  localparam logic [N-1:0] RST_C = RST_SKIP[N-1:0];
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW:0]  K_C   = K[IW:0];

  logic [K-1:0][N-1:0] skip_val_q;
  logic [K-1:0]        skip_vld_q;
  dir_e                dir_sel;
  logic [N-1:0]        lv;
  logic [N-1:0]        ld_start;
  logic [N-1:0]        st_nxt;
  logic                st_wrap;
  logic                st_found;
  logic [N-1:0]        ld_nxt;
  logic                ld_wrap_unused;
  logic                ld_found;
  logic                idx_ok;

`ifdef COUNTER_SKIP_DOWN_EN
  assign dir_sel = dir ? DIR_DOWN : DIR_UP;
`else
  assign dir_sel = DIR_UP;
`endif

  assign idx_ok = ({1'b0, cfg_idx} < K_C);

  // Out-of-range load values collapse to 0; the load search starts one step
  // behind so that the load value itself is the first candidate tested
  always_comb begin
    lv = (load_val > MAX_C) ? '0 : load_val;
    if (dir_sel == DIR_DOWN) ld_start = (lv == MAX_C) ? '0 : lv + ONE;
    else                     ld_start = (lv == '0) ? MAX_C : lv - ONE;
  end

  counter_skip_search #(.N(N), .MAX_VAL(MAX_VAL), .K(K)) u_step (
    .start    (cnt),
    .dir      (dir_sel),
    .skip_val (skip_val_q),
    .skip_vld (skip_vld_q),
    .nxt      (st_nxt),
    .wrapped  (st_wrap),
    .found    (st_found)
  );

  counter_skip_search #(.N(N), .MAX_VAL(MAX_VAL), .K(K)) u_load (
    .start    (ld_start),
    .dir      (dir_sel),
    .skip_val (skip_val_q),
    .skip_vld (skip_vld_q),
    .nxt      (ld_nxt),
    .wrapped  (ld_wrap_unused),
    .found    (ld_found)
  );

  // Skip table: entry 0 preloaded at reset, writes land next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_val_q    <= '0;
      skip_vld_q    <= '0;
      skip_val_q[0] <= RST_C;
      skip_vld_q[0] <= 1'b1;
    end else if (cfg_we && idx_ok) begin
      skip_val_q[cfg_idx] <= cfg_val;
      skip_vld_q[cfg_idx] <= cfg_vld;
    end
  end

  // Count register: load beats step; cnt holds if the search finds nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      tc <= 1'b0;
      if (ld_found) cnt <= ld_nxt;
    end else if (en && st_found) begin
      cnt <= st_nxt;
      tc  <= st_wrap;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_skip_set.sv
// Directed self-checking bench for counter_skip_set (default N=5, K=4).
module tb_counter_skip_set;

  logic       clk = 1'b0;
  logic       rst, en, load, cfg_we, cfg_vld, dir;
  logic [4:0] load_val, cfg_val;
  logic [1:0] cfg_idx;
  logic [4:0] cnt;
  logic       tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_skip_set dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_val  (cfg_val),
    .cfg_vld  (cfg_vld),
`ifdef COUNTER_SKIP_DOWN_EN
    .dir      (dir),
`endif
    .cnt      (cnt),
    .tc       (tc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [4:0] val, input logic vld);
    cfg_we = 1'b1; cfg_idx = idx; cfg_val = val; cfg_vld = vld;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step(input string tag, input int exp_cnt, input logic exp_tc);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    chk({tag, "_tc"}, 32'(tc), 32'(exp_tc));
  endtask

  initial begin
    int e;
    rst = 1'b1; en = 1'b0; load = 1'b0; cfg_we = 1'b0; cfg_vld = 1'b0; dir = 1'b0;
    load_val = '0; cfg_val = '0; cfg_idx = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_tc", 32'(tc), 0);

    // T1: free run, 3 skipped, wrap after 31
    e = 0;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      e = (e == 31) ? 0 : e + 1;
      if (e == 3) e = 4;
      tick();
      chk("t1_cnt", 32'(cnt), 32'(e));
      chk("t1_tc", 32'(tc), (e == 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;

    // T2: entries 1=4, 2=5; step from 2 lands on 6
    cfg(2'd1, 5'd4, 1'b1);
    cfg(2'd2, 5'd5, 1'b1);
    do_load(5'd2);
    chk("t2_load2", 32'(cnt), 2);
    do_step("t2_skip345", 6, 1'b0);
    cfg(2'd1, 5'd4, 1'b0);
    do_load(5'd31);
    chk("t2_load31", 32'(cnt), 31);
    do_step("t2_wrap", 0, 1'b1);
    do_step("t2_s1", 1, 1'b0);
    do_step("t2_s2", 2, 1'b0);
    do_step("t2_s4", 4, 1'b0);

    // same-cycle write uses the old table; a write never moves cnt
    do_load(5'd2);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_val = 5'd4; cfg_vld = 1'b1; en = 1'b1;
    tick();
    cfg_we = 1'b0; en = 1'b0;
    chk("cfg_old_tbl", 32'(cnt), 4);
    tick();
    chk("cnt_now_skipped_hold", 32'(cnt), 4);
    do_step("move_off_skipped", 6, 1'b0);

    // T3: load skipped value with en also high
    do_load(5'd10);
    chk("t3_pre", 32'(cnt), 10);
    load = 1'b1; load_val = 5'd3; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    chk("t3_cnt", 32'(cnt), 6);
    chk("t3_tc", 32'(tc), 0);

    // T4: skip 31 and 0 (table 3,0,5,31)
    cfg(2'd1, 5'd0, 1'b1);
    cfg(2'd3, 5'd31, 1'b1);
    do_load(5'd30);
    chk("t4_load30", 32'(cnt), 30);
    do_step("t4_wrap", 1, 1'b1);
    do_step("t4_after", 2, 1'b0);
    do_load(5'd31);
    chk("load_wrap_cnt", 32'(cnt), 1);
    chk("load_wrap_tc", 32'(tc), 0);

    // T5: reset mid-operation beats load, en and cfg_we
    do_load(5'd17);
    chk("t5_pre", 32'(cnt), 17);
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 5'd5;
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_val = 5'd9; cfg_vld = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; load = 1'b0; cfg_we = 1'b0;
    chk("t5_cnt", 32'(cnt), 0);
    chk("t5_tc", 32'(tc), 0);
    do_step("t5_s1", 1, 1'b0);
    do_step("t5_s2", 2, 1'b0);
    do_step("t5_s4", 4, 1'b0);
    do_load(5'd8);
    do_step("t5_9free", 9, 1'b0);
    do_load(5'd5);
    chk("t5_5free", 32'(cnt), 5);
    do_load(5'd30);
    do_step("t5_31free", 31, 1'b0);
    do_step("t5_wrap", 0, 1'b1);

`ifdef COUNTER_SKIP_DOWN_EN
    // T6: down-count
    dir = 1'b1;
    do_load(5'd4);
    chk("t6_load4", 32'(cnt), 4);
    do_step("t6_dn", 2, 1'b0);
    do_load(5'd0);
    chk("t6_load0", 32'(cnt), 0);
    do_step("t6_wrap", 31, 1'b1);
    dir = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
